// File: rtl/alu_md_if.sv
// Operand/result handshake bundle for alu_md: valid/ready on both the
// operand side and the result side.
interface alu_md_if #(
  parameter int WIDTH = 32
);
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] S1;
  logic [WIDTH-1:0] S2;
  logic [3:0]       OpCode;
  logic             MExt;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] OUT;
  logic             DivZero;

  modport master (
    output IN_VALID, S1, S2, OpCode, MExt, OUT_READY,
    input  IN_READY, OUT_VALID, OUT, DivZero
  );

  modport slave (
    input  IN_VALID, S1, S2, OpCode, MExt, OUT_READY,
    output IN_READY, OUT_VALID, OUT, DivZero
  );
endinterface

// File: rtl/alu_md.sv
// Execute-stage ALU with registered result, valid/ready flow control and
// RV32M multiply/divide; divide/remainder use an iterative restoring divider.
module alu_md #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input logic    CLK,
  input logic    RST_N,
  alu_md_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

  localparam logic [SHW:0] LAST = (SHW+1)'(WIDTH);

  state_t           state, state_nx;
  logic             in_ready, accept;
  logic [WIDTH-1:0] a, b;
  logic [SHW-1:0]   sh;

  logic             is_div, div_signed, div_rem;
  logic             div_zero, div_ovf, div_fast, start_div;

  logic [WIDTH-1:0] base_res, mul_res, fast_res, single_res;
  logic             single_dz;
  logic [2*WIDTH-1:0] ma, mb, prod;

  logic [WIDTH-1:0] quo, rem, dvsr;
  logic [SHW:0]     cnt;
  logic             neg_q, neg_r, d_rem;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] mag_a, mag_b, q_fix, r_fix, div_res;
  logic             div_done;

  logic [WIDTH-1:0] out_q;
  logic             dz_q;

  assign a  = bus.S1;
  assign b  = bus.S2;
  assign sh = b[SHW-1:0];

  assign in_ready      = (state == IDLE) || (state == DONE && bus.OUT_READY);
  assign accept        = bus.IN_VALID && in_ready;
  assign bus.IN_READY  = in_ready;
  assign bus.OUT_VALID = (state == DONE);
  assign bus.OUT       = out_q;
  assign bus.DivZero   = dz_q;

  // Divide decode: OpCode[0]=unsigned, OpCode[1]=remainder
  assign is_div     = bus.MExt && bus.OpCode[2];
  assign div_signed = ~bus.OpCode[0];
  assign div_rem    = bus.OpCode[1];
  assign div_zero   = (b == '0);
  assign div_ovf    = div_signed && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
  assign div_fast   = div_zero || div_ovf;
  assign start_div  = accept && is_div && !div_fast;

  always_comb begin
    base_res = '0;
    unique case (bus.OpCode)
      4'b0000: base_res = a + b;
      4'b1000: base_res = a - b;
      4'b0001: base_res = a << sh;
      4'b0010: base_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'b0011: base_res = {{(WIDTH-1){1'b0}}, (a < b)};
      4'b0100: base_res = a ^ b;
      4'b0101: base_res = a >> sh;
      4'b1101: base_res = WIDTH'($signed(a) >>> sh);
      4'b0110: base_res = a | b;
      4'b0111: base_res = a & b;
      default: base_res = '0;
    endcase
  end

  // One shared 2W multiplier; operand extension selects the signedness
  always_comb begin
    ma = {{WIDTH{1'b0}}, a};
    mb = {{WIDTH{1'b0}}, b};
    if (bus.OpCode[1:0] == 2'b01 || bus.OpCode[1:0] == 2'b10)
      ma = {{WIDTH{a[WIDTH-1]}}, a};
    if (bus.OpCode[1:0] == 2'b01)
      mb = {{WIDTH{b[WIDTH-1]}}, b};
    prod    = ma * mb;
    mul_res = (bus.OpCode[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    if (div_zero) fast_res = div_rem ? a : '1;
    else          fast_res = div_rem ? '0 : a;
    single_res = base_res;
    if (bus.MExt) single_res = bus.OpCode[2] ? fast_res : mul_res;
    single_dz  = is_div && div_zero;
  end

  assign mag_a    = (div_signed && a[WIDTH-1]) ? -a : a;
  assign mag_b    = (div_signed && b[WIDTH-1]) ? -b : b;
  assign trial    = {rem, quo[WIDTH-1]} - {1'b0, dvsr};
  assign div_done = (state == DIVIDE) && (cnt == LAST);
  assign q_fix    = neg_q ? -quo : quo;
  assign r_fix    = neg_r ? -rem : rem;
  assign div_res  = d_rem ? r_fix : q_fix;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = start_div ? DIVIDE : DONE;
      DIVIDE:  if (div_done) state_nx = DONE;
      DONE: begin
        if (accept)              state_nx = start_div ? DIVIDE : DONE;
        else if (bus.OUT_READY)  state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nx;
  end

  // Dividend shifts out of quo as quotient bits shift in; cnt==WIDTH is the sign-fix cycle
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      quo   <= '0;
      rem   <= '0;
      dvsr  <= '0;
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      d_rem <= 1'b0;
    end else if (start_div) begin
      quo   <= mag_a;
      rem   <= '0;
      dvsr  <= mag_b;
      cnt   <= '0;
      neg_q <= div_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r <= div_signed && a[WIDTH-1];
      d_rem <= div_rem;
    end else if (state == DIVIDE && cnt != LAST) begin
      if (!trial[WIDTH]) begin
        rem <= trial[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b1};
      end else begin
        rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
        quo <= {quo[WIDTH-2:0], 1'b0};
      end
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_q <= '0;
      dz_q  <= 1'b0;
    end else if (accept && !start_div) begin
      out_q <= single_res;
      dz_q  <= single_dz;
    end else if (div_done) begin
      out_q <= div_res;
      dz_q  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_md.sv
// Scoreboard bench for alu_md: expected results queued at accept, compared
// (value, DivZero and latency) when the DUT presents them.
module tb_alu_md;
  localparam int W = 32;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  alu_md_if #(.WIDTH(W)) bus ();
  alu_md #(.WIDTH(W)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));

  typedef struct {
    logic [31:0] out;
    logic        dz;
    int          acc;
    int          lat;
    string       tag;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   head_seen = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] model(input logic mext, input logic [3:0] op,
                                        input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int          sa, sb;
    logic [31:0] r;
    logic        dz;
    sa = a; sb = b; r = '0; dz = 1'b0; p = '0;
    if (!mext) begin
      case (op)
        4'd0:  r = a + b;
        4'd8:  r = a - b;
        4'd1:  r = a << b[4:0];
        4'd2:  r = (sa < sb) ? 32'd1 : 32'd0;
        4'd3:  r = (a < b) ? 32'd1 : 32'd0;
        4'd4:  r = a ^ b;
        4'd5:  r = a >> b[4:0];
        4'd13: r = sa >>> b[4:0];
        4'd6:  r = a | b;
        4'd7:  r = a & b;
        default: r = '0;
      endcase
    end else begin
      case (op[2:0])
        3'd0: begin p = longint'(sa) * longint'(sb); r = p[31:0]; end
        3'd1: begin p = longint'(sa) * longint'(sb); r = p[63:32]; end
        3'd2: begin p = longint'(sa) * longint'({32'b0, b}); r = p[63:32]; end
        3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
        3'd4: if (b == 0) begin r = '1; dz = 1'b1; end
              else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
              else r = sa / sb;
        3'd5: if (b == 0) begin r = '1; dz = 1'b1; end
              else r = a / b;
        3'd6: if (b == 0) begin r = a; dz = 1'b1; end
              else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
              else r = sa % sb;
        default: if (b == 0) begin r = a; dz = 1'b1; end
                 else r = a % b;
      endcase
    end
    return {dz, r};
  endfunction

  // Called at posedge+#1; returns at posedge+#1 after the accepting edge
  task automatic issue(input logic mext, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eout, input logic edz,
                       input string tag);
    bit   rdy;
    exp_t e;
    bit   ovf;
    bus.IN_VALID = 1'b1;
    bus.MExt     = mext;
    bus.OpCode   = op;
    bus.S1       = a;
    bus.S2       = b;
    rdy = 1'b0;
    for (int n = 0; n < 200 && !rdy; n++) begin
      @(negedge CLK);
      rdy = bus.IN_READY;
      @(posedge CLK);
      #1;
    end
    check({tag, "_acc"}, 64'(rdy), 64'd1);
    if (rdy) begin
      ovf   = !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
      e.out = eout;
      e.dz  = edz;
      e.acc = cyc;
      e.lat = (mext && op[2] && b != 0 && !ovf) ? W + 1 : 0;
      e.tag = tag;
      sbq.push_back(e);
    end
  endtask

  task automatic issue_m(input logic mext, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input string tag);
    logic [32:0] m;
    m = model(mext, op, a, b);
    issue(mext, op, a, b, m[31:0], m[32], tag);
  endtask

  task automatic drain();
    bus.IN_VALID = 1'b0;
    for (int n = 0; n < 100 && sbq.size() > 0; n++) begin
      @(posedge CLK);
      #1;
    end
    check("drain", 64'(sbq.size()), 64'd0);
  endtask

  task automatic div_watch(input string tag);
    int r;
    r = 0;
    bus.IN_VALID = 1'b0;
    for (int n = 0; n < 60 && sbq.size() > 0; n++) begin
      @(negedge CLK);
      if (!bus.OUT_VALID && bus.IN_READY) r++;
      @(posedge CLK);
      #1;
    end
    check({tag, "_rdy"}, 64'(r), 64'd0);
    check({tag, "_done"}, 64'(sbq.size()), 64'd0);
  endtask

  always @(negedge CLK) begin
    if (RST_N && bus.OUT_VALID) begin
      if (sbq.size() == 0) begin
        check("sb_empty", 64'(sbq.size()), 64'd1);
      end else begin
        if (!head_seen) begin
          head_seen = 1'b1;
          check({sbq[0].tag, "_lat"}, 64'(cyc - sbq[0].acc), 64'(sbq[0].lat));
        end
        check(sbq[0].tag, {31'b0, bus.DivZero, bus.OUT}, {31'b0, sbq[0].dz, sbq[0].out});
        if (bus.OUT_READY) begin
          void'(sbq.pop_front());
          head_seen = 1'b0;
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int          c0, c1;
    logic [3:0]  bops [10];
    logic [3:0]  rop;
    logic        rmx;
    logic [31:0] ra, rb;
    bops = '{4'd0, 4'd8, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd13, 4'd6, 4'd7};

    bus.IN_VALID  = 1'b0;
    bus.S1        = '0;
    bus.S2        = '0;
    bus.OpCode    = '0;
    bus.MExt      = 1'b0;
    bus.OUT_READY = 1'b1;

    repeat (3) @(posedge CLK);
    #1;
    check("rst_valid", 64'(bus.OUT_VALID), 64'd0);
    check("rst_out", 64'(bus.OUT), 64'd0);
    check("rst_dz", 64'(bus.DivZero), 64'd0);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    check("rst_rdy", 64'(bus.IN_READY), 64'd1);

    issue(1'b0, 4'b1000, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, "sub");
    issue(1'b0, 4'b1101, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, "sra");
    issue(1'b0, 4'b0011, 32'd1, 32'hFFFF_FFFF, 32'd1, 1'b0, "sltu");
    issue(1'b0, 4'b1111, 32'd1, 32'd2, 32'd0, 1'b0, "bad_op");
    drain();

    c0 = cyc;
    for (int i = 0; i < 10; i++) begin
      issue_m(1'b0, bops[i], $urandom, $urandom, $sformatf("b2b%0d", i));
      if (i == 0) c0 = cyc;
    end
    c1 = cyc;
    check("b2b_span", 64'(c1 - c0), 64'd9);
    drain();

    issue(1'b1, 4'b0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, "mulh");
    issue(1'b1, 4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, "mulhu");
    issue(1'b1, 4'b0010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b0, "mulhsu");
    issue(1'b1, 4'b0000, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, "mul");
    issue(1'b1, 4'b1000, 32'd12345, 32'd1000, 32'd12345000, 1'b0, "mul_op3");
    drain();

    issue(1'b1, 4'b0100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, "div");
    div_watch("div");
    issue(1'b1, 4'b0110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, "rem");
    div_watch("rem");
    issue(1'b1, 4'b0101, 32'd100, 32'd7, 32'd14, 1'b0, "divu");
    div_watch("divu");

    issue(1'b1, 4'b0101, 32'd9, 32'd0, 32'hFFFF_FFFF, 1'b1, "divu0");
    issue(1'b1, 4'b0110, 32'd9, 32'd0, 32'd9, 1'b1, "rem0");
    issue(1'b1, 4'b0100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, "div_ovf");
    issue(1'b1, 4'b0110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, "rem_ovf");
    drain();

    bus.OUT_READY = 1'b0;
    issue(1'b0, 4'b0000, 32'd10, 32'd20, 32'd30, 1'b0, "bp_add");
    bus.IN_VALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("bp_rdy", 64'(bus.IN_READY), 64'd0);
      check("bp_valid", 64'(bus.OUT_VALID), 64'd1);
      @(posedge CLK);
      #1;
    end
    bus.OUT_READY = 1'b1;
    c0 = cyc;
    issue(1'b0, 4'b0100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1'b0, "bp_xor");
    check("bp_same_edge", 64'(cyc - c0), 64'd1);
    drain();

    for (int i = 0; i < 30; i++) begin
      rmx = 1'($urandom_range(0, 1));
      rop = 4'($urandom_range(0, 15));
      ra  = (i % 3 == 0) ? 32'($urandom_range(0, 50)) : $urandom;
      rb  = (i % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if (i % 5 == 0) rb = -rb;
      issue_m(rmx, rop, ra, rb, $sformatf("rnd%0d", i));
    end
    drain();

    issue(1'b1, 4'b0100, 32'd100, 32'd3, 32'd33, 1'b0, "div_abort");
    bus.IN_VALID = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    RST_N = 1'b0;
    #1;
    check("abort_valid", 64'(bus.OUT_VALID), 64'd0);
    check("abort_out", 64'(bus.OUT), 64'd0);
    sbq.delete();
    head_seen = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    @(negedge CLK);
    check("abort_valid2", 64'(bus.OUT_VALID), 64'd0);
    check("abort_rdy", 64'(bus.IN_READY), 64'd1);
    @(posedge CLK);
    #1;
    issue(1'b0, 4'b0000, 32'd3, 32'd4, 32'd7, 1'b0, "add_after_rst");
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_md.md
Name: alu_md

Overview:
- Parametrised, handshaked successor to the processor's combinational ALU.
- Adds registered results, valid/ready flow control and the RV32M multiply/divide operations.
- Base ops and multiplies complete in one cycle. Divide/remainder use an iterative restoring divider.
- Sits in the execute stage between operand mux and writeback register; stalls the pipe via IN_READY.

Parameters:
- WIDTH, 32, operand/result width in bits (power of two, >=8).
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  reset, asynchronous, active-low.
- IN_VALID  input  1  operands/opcode valid.
- IN_READY  output  1  block can accept an operation this cycle.
- S1  input  WIDTH  source operand 1.
- S2  input  WIDTH  source operand 2.
- OpCode  input  4  operation select.
- MExt  input  1  0 = base op set, 1 = M-extension op set.
- OUT_VALID  output  1  result valid.
- OUT_READY  input  1  consumer accepts result.
- OUT  output  WIDTH  result.
- DivZero  output  1  divisor was zero; qualified by OUT_VALID.

Behaviour:
- One clock domain, CLK. RST_N is asynchronous, active-low.
- Reset: state IDLE, OUT=0, OUT_VALID=0, DivZero=0, divider registers 0. Reset mid-divide aborts the operation; no result is produced.
- Accept: an operation is taken on a rising edge with IN_VALID && IN_READY. Operands and opcode are captured; later input changes are ignored.
- IN_READY = (state==IDLE) || (state==DONE && OUT_READY). This gives back-to-back throughput of 1 op/cycle for single-cycle ops.
- MExt=0, single cycle. Codes: 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND; any other code gives OUT=0.
  - Shifts use S2[SHW-1:0].
  - Add/sub wrap modulo 2^WIDTH.
- MExt=1: OpCode[3] ignored; OpCode[2:0] selects 000 MUL (low WIDTH), 001 MULH (s×s high), 010 MULHSU (s×u high), 011 MULHU (u×u high), 100 DIV, 101 DIVU, 110 REM, 111 REMU.
  - Products are computed at 2*WIDTH width, then sliced.
- FSM states: IDLE, DIVIDE, DONE.
  - IDLE→DONE on accept of a single-cycle op or a div fast-path case; result registered on the accepting edge, OUT_VALID=1 next cycle.
  - IDLE→DIVIDE on accept of any other div/rem. Runs exactly WIDTH iterations on magnitudes, then applies the sign fix (quotient negative iff signs differ; remainder takes dividend sign). Enters DONE with OUT_VALID=1 on edge WIDTH+1 after accept.
  - DONE: OUT, OUT_VALID and DivZero hold stable until OUT_READY=1. On that edge go to IDLE, or reload directly if a new op is accepted on the same edge.
  - DIVIDE: IN_READY=0; OUT_READY ignored.
- Div fast paths (1 cycle):
  - Divisor 0: DIV/DIVU give all ones; REM/REMU give S1; DivZero=1.
  - Signed overflow (S1 = most negative, S2 = -1): DIV gives S1; REM gives 0; DivZero=0.
- DivZero is 0 for all non-div ops.
- OUT_VALID never drops without the OUT_READY handshake.

Test Plan:
- Base ops, WIDTH=32, OUT_READY tied 1: SUB 5−7 → 0xFFFFFFFE; SRA 0x80000000>>>4 → 0xF8000000; SLTU 1<0xFFFFFFFF → 1. Each OUT_VALID one cycle after accept; 10 back-to-back ops produce 10 results in 10 consecutive cycles.
- Multiply: MULH 0xFFFFFFFF×0xFFFFFFFF → 0; MULHU same operands → 0xFFFFFFFE; MULHSU −1×2 → 0xFFFFFFFF; MUL 0x10000×0x10000 → 0.
- Divide: DIV −7/2 → 0xFFFFFFFD, REM −7/2 → 0xFFFFFFFF, DIVU 100/7 → 14. OUT_VALID exactly 33 cycles after accept; IN_READY=0 throughout DIVIDE.
- Corner cases: DIVU 9/0 → 0xFFFFFFFF, DivZero=1; REM 9/0 → 9; DIV 0x80000000/−1 → 0x80000000; REM same → 0. All valid after 1 cycle.
- Backpressure: OUT_READY=0 for 5 cycles after result → OUT/OUT_VALID/DivZero stable and IN_READY=0. Raise OUT_READY with IN_VALID=1 → the new op is accepted on the same edge.
- Reset: assert RST_N=0 at iteration 10 of a DIV → OUT_VALID=0, OUT=0 immediately (asynchronous). After release, IN_READY=1 and the next ADD 3+4 → 7.
